// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_pkg;
  localparam int          XLEN       = 32;
  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  function automatic logic is_signed_op(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  endfunction
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Pipeline-facing request/status bus of the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, rs_val, rt_val, flush, input busy, done, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, flush, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_divider_core.sv
// Restoring divider datapath on magnitudes: one quotient bit per step.
module muldiv_divider_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q, dvs_q;
  logic [XLEN+1:0] trial;
  logic            borrow;

  // Dividend shifts out of quo_q MSB-first while quotient bits shift in.
  assign trial  = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
  assign borrow = trial[XLEN+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= borrow ? {rem_q[XLEN-1:0], quo_q[XLEN-1]} : trial[XLEN:0];
      quo_q <= {quo_q[XLEN-2:0], ~borrow};
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[XLEN-1:0];
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MUL/DIV unit owning HI/LO; commits only on completion.
// HILO_FAST_MUL_EN selects a single-cycle multiplier (divide timing unchanged).
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN  = mips_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER_COUNT - 1);

  state_e            state_q;
  muldiv_op_e        op_in, op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q, neg_q, rneg_q, dz_q, sgn;
  logic [XLEN-1:0]   hi_q, lo_q, rs_q, mcand_q, a_mag, b_mag, quo, rem, q_fix, r_fix;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_fix, madd_sum;
  logic [XLEN:0]     mul_sum;

  assign op_in = muldiv_op_e'(bus.op);
  assign sgn   = is_signed_op(op_in);
  assign a_mag = (sgn && bus.rs_val[XLEN-1]) ? -bus.rs_val : bus.rs_val;
  assign b_mag = (sgn && bus.rt_val[XLEN-1]) ? -bus.rt_val : bus.rt_val;

  // Shift-add: upper half accumulates, multiplier bits retire out of the low half.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_d   = {mul_sum, prod_q[XLEN-1:1]};
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign madd_sum = {hi_q, lo_q} + prod_fix;
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = rneg_q ? -rem : rem;

`ifdef HILO_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = sgn
    ? 2*XLEN'($signed({{XLEN{bus.rs_val[XLEN-1]}}, bus.rs_val}) *
              $signed({{XLEN{bus.rt_val[XLEN-1]}}, bus.rt_val}))
    : {{XLEN{1'b0}}, bus.rs_val} * {{XLEN{1'b0}}, bus.rt_val};
`endif

  muldiv_divider_core #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      ((state_q == S_IDLE) && bus.start && !bus.flush &&
                  ((op_in == OP_DIV) || (op_in == OP_DIVU))),
    .step_i      (state_q == S_DIV),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      rs_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start && !bus.flush) begin
          op_q  <= op_in;
          cnt_q <= '0;
          neg_q <= sgn && (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
          case (op_in)
            OP_MTHI: begin hi_q <= bus.rs_val; done_q <= 1'b1; end
            OP_MTLO: begin lo_q <= bus.rs_val; done_q <= 1'b1; end
            OP_DIV, OP_DIVU: begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
              rneg_q  <= sgn && bus.rs_val[XLEN-1];
              dz_q    <= (bus.rt_val == '0);
              rs_q    <= bus.rs_val;
            end
            default: begin
`ifdef HILO_FAST_MUL_EN
              if ((op_in == OP_MADD) || (op_in == OP_MADDU))
                {hi_q, lo_q} <= {hi_q, lo_q} + fast_prod;
              else
                {hi_q, lo_q} <= fast_prod;
              done_q <= 1'b1;
`else
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              prod_q  <= {{XLEN{1'b0}}, b_mag};
              mcand_q <= a_mag;
`endif
            end
          endcase
        end
        S_MUL, S_DIV: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (state_q == S_MUL) prod_q <= prod_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          // A flush here still wins: nothing commits and no done pulse.
          if (!bus.flush) begin
            done_q <= 1'b1;
            case (op_q)
              OP_MADD, OP_MADDU: {hi_q, lo_q} <= madd_sum;
              OP_DIV, OP_DIVU: begin
                lo_q <= dz_q ? XLEN'(DIV_ZERO_Q) : q_fix;
                hi_q <= dz_q ? rs_q : r_fix;
              end
              default: {hi_q, lo_q} <= prod_fix;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

`ifdef HILO_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  hilo_muldiv_unit_if #(.XLEN(32)) ifc();

  hilo_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input muldiv_op_e op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.op     = op;
    ifc.rs_val = rs;
    ifc.rt_val = rt;
    @(negedge clk);
    ifc.start  = 1'b0;
    ifc.rs_val = 32'h0BAD_0BAD;
    ifc.rt_val = 32'h0000_0000;
  endtask

  // Counts negedges with busy high; bounded so a stuck unit still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (ifc.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input muldiv_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(op, rs, rt);
    wait_idle(n);
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".done"}, 64'(ifc.done), 64'd1);
    chk({tag, ".hi"}, 64'(ifc.hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(ifc.lo), 64'(elo));
    @(negedge clk);
    chk({tag, ".done_off"}, 64'(ifc.done), 64'd0);
  endtask

  initial begin
    ifc.start = 1'b0; ifc.op = 3'b000; ifc.flush = 1'b0;
    ifc.rs_val = '0;  ifc.rt_val = '0;
    #12;
    chk("rst.busy", 64'(ifc.busy), 64'd0);
    chk("rst.done", 64'(ifc.done), 64'd0);
    chk("rst.hi",   64'(ifc.hi),   64'd0);
    chk("rst.lo",   64'(ifc.lo),   64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mthi",  OP_MTHI,  32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h0);
    run_op("mtlo",  OP_MTLO,  32'h9ABC_DEF0, 32'h0, 0, 32'h1234_5678, 32'h9ABC_DEF0);

    run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("mult_nn", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD, MUL_LAT, 32'h0, 32'd21);

    run_op("div",    OP_DIV,  32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_pn", OP_DIV,  32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'd1, 32'hFFFF_FFFD);
    run_op("divu0",  OP_DIVU, 32'd7, 32'd0, DIV_LAT, 32'd7, 32'hFFFF_FFFF);
    run_op("div0",   OP_DIV,  32'hFFFF_FFF9, 32'd0, DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ov", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000);
    run_op("divu",   OP_DIVU, 32'hFFFF_FFFF, 32'd16, DIV_LAT, 32'd15, 32'h0FFF_FFFF);

    run_op("pre_hi", OP_MTHI, 32'h0, 32'h0, 0, 32'h0, 32'h0FFF_FFFF);
    run_op("pre_lo", OP_MTLO, 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 32'hFFFF_FFFF);
    run_op("maddu",  OP_MADDU, 32'd1, 32'd1, MUL_LAT, 32'd1, 32'h0);
    run_op("madd",   OP_MADD,  32'hFFFF_FFFF, 32'd1, MUL_LAT, 32'h0, 32'hFFFF_FFFF);
    run_op("madd_big", OP_MADD, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 32'd1, 32'hFFFF_FFFF);

    // Flush at busy cycle 10: no commit, no done.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    chk("flush.busy_before", 64'(ifc.busy), 64'd1);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    chk("flush.busy", 64'(ifc.busy), 64'd0);
    chk("flush.done", 64'(ifc.done), 64'd0);
    chk("flush.hi",   64'(ifc.hi),   64'd1);
    chk("flush.lo",   64'(ifc.lo),   64'hFFFF_FFFF);
    @(negedge clk);
    chk("flush.done2", 64'(ifc.done), 64'd0);

    // start together with flush in IDLE is dropped.
    @(negedge clk);
    ifc.flush = 1'b1; ifc.start = 1'b1; ifc.op = OP_MTHI; ifc.rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    ifc.flush = 1'b0; ifc.start = 1'b0;
    chk("flst.done", 64'(ifc.done), 64'd0);
    chk("flst.hi",   64'(ifc.hi),   64'd1);

    // start during busy is ignored, and operand changes have no effect.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_MTLO; ifc.rs_val = 32'hAAAA_AAAA; ifc.rt_val = 32'd3;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_idle(cyc);
    chk("ign.lat",  64'(cyc + 5), 64'(DIV_LAT));
    chk("ign.done", 64'(ifc.done), 64'd1);
    chk("ign.hi",   64'(ifc.hi), 64'd2);
    chk("ign.lo",   64'(ifc.lo), 64'd14);

    // Async reset mid-multiply clears everything immediately.
    run_op("pre_rst", OP_MTHI, 32'h5555_5555, 32'h0, 0, 32'h5555_5555, 32'd14);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(ifc.busy), 64'd0);
    chk("arst.hi",   64'(ifc.hi),   64'd0);
    chk("arst.lo",   64'(ifc.lo),   64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", OP_MULTU, 32'd6, 32'd7, MUL_LAT, 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside the EX-stage ALU and drives the ALU's hi_in/lo_in operands.
- Executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MTHI/MTLO over multiple cycles; the pipeline stalls on busy.
- Results commit to HI/LO only on completion, so a flush never corrupts architectural state.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MTHI, 111 MTLO.
- rs_val  in  XLEN  operand A (dividend / multiplicand / move source).
- rt_val  in  XLEN  operand B (divisor / multiplier).
- flush  in  1  abort the in-flight operation.
- busy  out  1  high while an operation is in flight; pipeline stall request.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  XLEN  architectural HI; feeds ALU hi_in.
- lo  out  XLEN  architectural LO; feeds ALU lo_in.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards all work.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1, edge E0:
  - MTHI/MTLO: hi (or lo) <= rs_val at E0; done=1 for the following cycle; busy stays 0.
  - MULT/MULTU/MADD/MADDU: latch operands as magnitudes (signed ops take absolute value and record the result sign); go to MUL, busy=1, counter=0.
  - DIV/DIVU: same latching; go to DIV, busy=1.
- MUL: radix-2 shift-add, one multiplier bit per edge, 64-bit partial product. After 32 edges (E1..E32) go to FIX.
- DIV: restoring division, one quotient bit per edge over a 33-bit remainder. After 32 edges go to FIX.
- FIX, edge E33:
  - Apply sign correction.
  - MULT/MULTU: {hi,lo} <= product.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + product, mod 2^64. MADD adds the signed product, MADDU the unsigned product.
  - DIV/DIVU: lo <= quotient, hi <= remainder.
  - Return to IDLE, busy=0, done=1 for one cycle.
  - Total latency from start edge to commit: 33 edges.
- Signed division: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero, both DIV and DIVU: lo=32'hFFFFFFFF, hi=rs_val. Takes full latency; no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy=1 is ignored; no queuing.
- flush=1 in any non-IDLE state: next edge goes to IDLE, busy=0, done=0, hi/lo unchanged.
- flush has priority over FIX commit.
- flush and start together in IDLE: start is ignored.
- hi/lo change only at a commit edge or reset.
- Operands are captured at start. rs_val/rt_val may change during busy without effect.

Optional Feature:
- Macro: HILO_FAST_MUL_EN.
- Defined:
  - MULT/MULTU/MADD/MADDU use a single-cycle combinational 64-bit multiply.
  - Commit occurs at E0 itself, done pulses the next cycle, busy never asserts.
  - DIV timing is unchanged.
- Undefined: iterative 33-edge multiply as described in Behaviour; no hardware multiplier is inferred.

Decomposition:
- Package mips_pkg holds:
  - muldiv_op_e enum (the 3-bit op codes above).
  - state enum.
  - XLEN default.
  - constants DIV_ZERO_Q=32'hFFFFFFFF and ITER_COUNT=32.
- One sub-module, muldiv_divider_core: the iterative restoring divider datapath (remainder/quotient registers, step logic).
- Control FSM, multiply path, and HI/LO registers stay in the top module.

Test Plan:
- Reset, then MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; done pulse after each; busy never 1.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0, lo=0xFFFFFFFF; MADDU rs=1, rt=1 -> hi=1, lo=0; then MADD rs=-1, rt=1 -> hi=0, lo=0xFFFFFFFF.
- Start DIV, assert flush at cycle 10 -> busy drops next cycle, no done, hi/lo unchanged. start during busy ignored; async reset mid-MUL -> hi=lo=0 immediately.
